// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store front end for the shared SRAM port.
// Converts LB/LBU/LH/LHU/LW/SB/SH/SW into word accesses on memory_stage.
// Sub-word stores run as a two-cycle read-modify-write. Loads take two cycles.
// The port goes back to instruction fetch whenever no data access is in progress.
// Ports:
//   mem_clk, reset            clock; synchronous active-high reset
//   req_*                     execute-stage request, held stable while stall=1
//   stall                     freeze upstream stages
//   rsp_valid, rsp_rdata      load result (1-cycle pulse)
//   fault                     misaligned / out-of-range / illegal size (1-cycle pulse)
//   mem_select .. mem_wren    drive memory_stage (select=1 -> fetch)
//   mem_q                     SRAM read data, valid one cycle after the address
module mem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        mem_clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        fault,
  output logic        mem_select,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  localparam int unsigned RANGE_SHIFT = ADDR_WIDTH + 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_DATA = 2'd1;
  localparam logic [1:0] S_RMW_WRITE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;

  // Bit position of the addressed lane inside the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size);
    logic [4:0] s;
    s = 5'd0;
    if (BIG_ENDIAN) begin
      if (size == SZ_BYTE)      s = {~off, 3'b000};
      else if (size == SZ_HALF) s = {~off[1], 4'b0000};
    end else begin
      if (size == SZ_BYTE)      s = {off, 3'b000};
      else if (size == SZ_HALF) s = {off[1], 4'b0000};
    end
    return s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    logic [31:0] m;
    if (size == SZ_BYTE)      m = 32'h0000_00FF;
    else if (size == SZ_HALF) m = 32'h0000_FFFF;
    else                      m = 32'hFFFF_FFFF;
    return m;
  endfunction

  logic        req_fault_c;
  logic [4:0]  shift_c;
  logic [31:0] lane_c;
  logic [31:0] mask_c;
  logic [31:0] load_ext_c;
  logic [31:0] merge_c;

  // Request fault: misaligned, illegal size, or outside the SRAM word range.
  always_comb begin
    req_fault_c = 1'b0;
    if (req_size == 2'd3)                                  req_fault_c = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])                req_fault_c = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)     req_fault_c = 1'b1;
    if ((req_addr >> RANGE_SHIFT) != 32'd0)                req_fault_c = 1'b1;
  end

  // Load extraction and store merge for the latched lane.
  always_comb begin
    shift_c = lane_shift(off_q, size_q);
    lane_c  = mem_q >> shift_c;
    mask_c  = lane_mask(size_q) << shift_c;
    merge_c = (mem_q & ~mask_c) | ((wdata_q << shift_c) & mask_c);
    if (size_q == SZ_BYTE)
      load_ext_c = uns_q ? {24'd0, lane_c[7:0]} : {{24{lane_c[7]}}, lane_c[7:0]};
    else if (size_q == SZ_HALF)
      load_ext_c = uns_q ? {16'd0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
    else
      load_ext_c = mem_q;
  end

  // Next-state and port outputs; reset forces the idle/fetch values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    stall      = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'd0;
    fault      = 1'b0;
    mem_select = 1'b1;
    mem_addr   = 30'd0;
    mem_wdata  = 32'd0;
    mem_wren   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mem_select = 1'b0;
            if (req_fault_c) begin
              fault = 1'b1;
            end else begin
              mem_addr = req_addr[31:2];
              if (req_write && req_size == SZ_WORD) begin
                mem_wdata = req_wdata;
                mem_wren  = 1'b1;
              end else begin
                stall   = 1'b1;
                addr_d  = req_addr[31:2];
                off_d   = req_addr[1:0];
                size_d  = req_size;
                uns_d   = req_unsigned;
                wdata_d = req_wdata;
                state_d = req_write ? S_RMW_WRITE : S_LOAD_DATA;
              end
            end
          end
        end
        S_LOAD_DATA: begin
          mem_select = 1'b0;
          mem_addr   = addr_q;
          rsp_valid  = 1'b1;
          rsp_rdata  = load_ext_c;
          state_d    = S_IDLE;
        end
        S_RMW_WRITE: begin
          mem_select = 1'b0;
          mem_addr   = addr_q;
          mem_wdata  = merge_c;
          mem_wren   = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and latched request registers.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 30'd0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits directly upstream of memory_stage, between the execute-stage result and the shared instruction/data SRAM port.
- Converts byte-addressed load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses on memory_stage.
- Performs sub-word stores as a two-cycle read-modify-write, because the SRAM writes whole words only.
- Extracts and extends load data, arbitrates the port against instruction fetch, and stalls the pipeline while an access is in flight.

Parameters:
ADDR_WIDTH, 12, number of SRAM word-address bits; word addresses outside this range fault.
BIG_ENDIAN, 1, 1 = byte offset 0 maps to q[31:24] (MIPS); 0 = byte offset 0 maps to q[7:0].

Ports:
mem_clk  in  1  clock; same clock as the SRAM inclock.
reset  in  1  synchronous, active-high.
req_valid  in  1  execute stage presents a memory op; held stable while stall=1.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as a fault.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
stall  out  1  freeze upstream stages this cycle.
rsp_valid  out  1  load result valid this cycle (1-cycle pulse).
rsp_rdata  out  32  extended load result.
fault  out  1  misaligned, out-of-range or illegal-size access; 1-cycle pulse, no memory side effect.
mem_select  out  1  to memory_stage.select: 1 = fetch (d_pc), 0 = data.
mem_addr  out  30  to memory_stage.addr_in: word address = req_addr[31:2] or the latched word address.
mem_wdata  out  32  to memory_stage.data_in.
mem_wren  out  1  to memory_stage.mem_wren.
mem_q  in  32  from memory_stage.out; valid the cycle after the address is presented.

Behaviour:
Timing and fault checks
- The SRAM samples address/data/wren on the rising mem_clk; read data appears on mem_q the following cycle.
- Accept condition: state IDLE, req_valid=1, reset=0.
- Fault: half with addr[0]=1, word with addr[1:0]!=0, req_size=3, or req_addr[31:ADDR_WIDTH+2]!=0.
  - On a fault: fault=1 for the accept cycle only; mem_wren=0, stall=0, rsp_valid=0; state stays IDLE.

States: IDLE, LOAD_DATA, RMW_WRITE (2-bit encoding).

IDLE
- No valid request: mem_select=1, mem_wren=0, stall=0.
- SW: mem_select=0, mem_addr=req_addr[31:2], mem_wdata=req_wdata, mem_wren=1, stall=0. Single cycle; stay in IDLE.
- Load: mem_select=0, mem_addr=req_addr[31:2], mem_wren=0, stall=1.
  - Latch word address, offset, size and unsigned flag; go to LOAD_DATA.
- SB/SH: mem_select=0, read the target word, stall=1.
  - Latch word address, offset, size and req_wdata; go to RMW_WRITE.

LOAD_DATA
- mem_select=0, mem_wren=0, stall=0.
- rsp_valid=1; rsp_rdata is the selected byte/half of mem_q (combinational), extended per the latched unsigned flag. Word loads pass mem_q through.
- Next state: IDLE.
- Load-to-use latency: 2 cycles from accept to result.

RMW_WRITE
- mem_select=0, mem_addr=latched word address, mem_wren=1, stall=0.
- mem_wdata = mem_q with the target lane(s) replaced by the latched data; all other lanes unchanged.
- Next state: IDLE.

Lane mapping (BIG_ENDIAN=1)
- Byte offset k occupies bits [31-8k : 24-8k].
- Half offset 0 occupies [31:16]; half offset 2 occupies [15:0].

Boundary rules
- While not in IDLE, req_* is ignored. The still-held request is the one in flight and is never re-accepted.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately following LOAD_DATA or RMW_WRITE.
- Fetch: mem_select=1 only in IDLE with no accepted request. Fetch is starved during data accesses; the pipeline is stalled during those cycles anyway.
- Reset has priority over all else in its cycle:
  - mem_wren=0, stall=0, rsp_valid=0, fault=0, mem_select=1.
  - State returns to IDLE even mid-RMW: the in-flight write is dropped and memory keeps its old word.
- Reset values of registered state: state=IDLE; latched address/offset/size/data = 0.
- Combinational outputs take these values in the reset cycle: stall=0, rsp_valid=0, rsp_rdata=0, fault=0, mem_select=1, mem_addr=0, mem_wdata=0, mem_wren=0.

Test Plan:
1. SW addr=0x0000_0010, data=0xDEADBEEF, then LW 0x10 -> one write cycle with mem_addr=4, stall=0; the load stalls 1 cycle, then rsp_valid=1 with rsp_rdata=0xDEADBEEF.
2. Word 0x11223344 at 0x20; LB 0x23 -> 0x00000044. LB 0x20 with word 0x80FF0000 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x22 on word 0x1234_8001 -> 0xFFFF8001.
3. SB 0x21 with data 0x000000AA onto 0x11223344 -> cycle 1 read with stall=1, cycle 2 mem_wren=1 and mem_wdata=0x11AA3344; a subsequent LW returns 0x11AA3344.
4. LH 0x21, LW 0x22, req_size=3, and LW 0x0001_0000 with ADDR_WIDTH=12 -> fault=1 for one cycle each, mem_wren=0, stall=0, no rsp_valid.
5. SH 0x30 held with req_valid; reset asserted during the RMW_WRITE cycle -> mem_wren=0 and state IDLE; the word at 0x30 is unchanged; next cycle mem_select=1.
6. SB then LB back-to-back with req_valid held continuously -> exactly one write and one read; stall pattern 1,0,1,0; the SB is not replayed.
